// File: rtl/tpu_dispatch_pkg.sv
// Shared MPU types and dispatch definitions for the per-TPU instruction dispatcher.
package pkg_mpu;

  typedef logic [3:0]  mpu_issue_no_t;
  typedef logic [31:0] instr_t;

  typedef enum logic [1:0] {
    DISP_IDLE,
    DISP_SEND,
    DISP_BACKOFF,
    DISP_WAIT_TERM
  } disp_state_t;

  localparam int DISP_LEN_W = 10;
  typedef logic [DISP_LEN_W-1:0] disp_len_t;

  localparam int DISP_WDOG_CYCLES = 4096;

endpackage

// File: rtl/tpu_dispatch_wdog.sv
// Term-wait watchdog: counts cycles while run is high, restarts on clear,
// and flags expiry during the LIMIT-th consecutive run cycle.
module tpu_dispatch_wdog
  import pkg_mpu::*;
#(
  parameter int LIMIT = DISP_WDOG_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (run && !expire) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign expire = run && !clear && (count_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/tpu_dispatch.sv
// Per-TPU dispatcher: streams a thread's instructions into one TPU, replays on
// Nack, then waits for the matching Term. Optional watchdog: TPU_DISPATCH_WDOG_EN.
module tpu_dispatch
  import pkg_mpu::*;
#(
  parameter int IADDR_W     = 10,
  parameter int LEN_W       = $bits(disp_len_t),
  parameter int WDOG_CYCLES = DISP_WDOG_CYCLES
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                I_Start,
  input  mpu_issue_no_t       I_IssueNo,
  input  logic [IADDR_W-1:0]  I_Base,
  input  logic [LEN_W-1:0]    I_Length,
  output logic                O_Start_Ack,
  output logic                O_IMem_Re,
  output logic [IADDR_W-1:0]  O_IMem_Addr,
  input  instr_t              I_IMem_Instr,
  output logic                O_TPU_Req,
  output mpu_issue_no_t       O_TPU_IssueNo,
  output instr_t              O_TPU_Instr,
  input  logic                I_TPU_Nack,
  input  logic                I_TPU_Term,
  input  mpu_issue_no_t       I_TPU_IssueNo,
  output logic                O_Busy,
  output logic                O_Done,
  output mpu_issue_no_t       O_Done_IssueNo,
  output logic                O_Timeout
);

  disp_state_t          state;
  mpu_issue_no_t        issue_q;
  logic [IADDR_W-1:0]   base_q;
  logic [LEN_W-1:0]     len_q;
  logic [LEN_W-1:0]     fetch_q;
  logic [LEN_W-1:0]     acc_q;
  logic [LEN_W-1:0]     acc_next;
  logic                 rd_valid_q;
  logic                 req_q;
  instr_t               instr_q;
  logic                 term_seen_q;
  logic                 done_q;
  logic                 timeout_q;
  mpu_issue_no_t        done_issue_q;

  logic start_ack;
  logic fetch_en;
  logic accept;
  logic reject;
  logic term_match;
  logic wdog_expire;

  assign start_ack  = I_Start && (state == DISP_IDLE) && (I_Length != '0);
  assign fetch_en   = (state == DISP_SEND) && (fetch_q < len_q);
  assign accept     = req_q && !I_TPU_Nack;
  assign reject     = req_q && I_TPU_Nack;
  assign term_match = I_TPU_Term && (I_TPU_IssueNo == issue_q);
  assign acc_next   = acc_q + LEN_W'(1);

`ifdef TPU_DISPATCH_WDOG_EN
  tpu_dispatch_wdog #(
    .LIMIT (WDOG_CYCLES)
  ) u_wdog (
    .clock  (clock),
    .reset  (reset),
    .clear  (state != DISP_WAIT_TERM),
    .run    (state == DISP_WAIT_TERM),
    .expire (wdog_expire)
  );
`else
  // The limit only matters when the watchdog is built in.
  logic unused_wdog;
  assign unused_wdog = ^32'(WDOG_CYCLES);
  assign wdog_expire = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= DISP_IDLE;
      issue_q      <= '0;
      base_q       <= '0;
      len_q        <= '0;
      fetch_q      <= '0;
      acc_q        <= '0;
      rd_valid_q   <= 1'b0;
      req_q        <= 1'b0;
      instr_q      <= '0;
      term_seen_q  <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      done_issue_q <= '0;
    end else begin
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      case (state)
        DISP_IDLE: begin
          if (start_ack) begin
            issue_q     <= I_IssueNo;
            base_q      <= I_Base;
            len_q       <= I_Length;
            fetch_q     <= '0;
            acc_q       <= '0;
            rd_valid_q  <= 1'b0;
            req_q       <= 1'b0;
            term_seen_q <= 1'b0;
            state       <= DISP_SEND;
          end
        end

        DISP_SEND: begin
          if (term_match) term_seen_q <= 1'b1;
          if (reject) begin
            // Drop both reads still in flight and refetch from the rejected beat.
            req_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            fetch_q    <= acc_q;
            state      <= DISP_BACKOFF;
          end else begin
            rd_valid_q <= fetch_en;
            if (fetch_en) fetch_q <= fetch_q + LEN_W'(1);
            req_q <= rd_valid_q;
            if (rd_valid_q) instr_q <= I_IMem_Instr;
            if (accept) begin
              acc_q <= acc_next;
              if (acc_next == len_q) begin
                req_q      <= 1'b0;
                rd_valid_q <= 1'b0;
                state      <= DISP_WAIT_TERM;
              end
            end
          end
        end

        DISP_BACKOFF: begin
          if (term_match) term_seen_q <= 1'b1;
          if (!I_TPU_Nack) state <= DISP_SEND;
        end

        DISP_WAIT_TERM: begin
          if (term_match || term_seen_q) begin
            done_q       <= 1'b1;
            done_issue_q <= issue_q;
            term_seen_q  <= 1'b0;
            state        <= DISP_IDLE;
          end else if (wdog_expire) begin
            done_q       <= 1'b1;
            timeout_q    <= 1'b1;
            done_issue_q <= issue_q;
            state        <= DISP_IDLE;
          end
        end

        default: state <= DISP_IDLE;
      endcase
    end
  end

  assign O_Start_Ack    = start_ack;
  assign O_IMem_Re      = fetch_en;
  assign O_IMem_Addr    = fetch_en ? (base_q + IADDR_W'(fetch_q)) : '0;
  assign O_TPU_Req      = req_q;
  assign O_TPU_IssueNo  = issue_q;
  assign O_TPU_Instr    = instr_q;
  assign O_Busy         = (state != DISP_IDLE);
  assign O_Done         = done_q;
  assign O_Done_IssueNo = done_issue_q;
  assign O_Timeout      = timeout_q;

endmodule

// File: tb/tb_tpu_dispatch.sv
// Scoreboard bench for tpu_dispatch: directed threads push expected beats and
// completions; negedge monitors pop and compare. Watchdog cases follow TPU_DISPATCH_WDOG_EN.
module tb_tpu_dispatch;
  import pkg_mpu::*;

  logic           clock = 1'b0;
  logic           reset;
  logic           I_Start;
  mpu_issue_no_t  I_IssueNo;
  logic [9:0]     I_Base;
  logic [9:0]     I_Length;
  logic           O_Start_Ack;
  logic           O_IMem_Re;
  logic [9:0]     O_IMem_Addr;
  instr_t         I_IMem_Instr;
  logic           O_TPU_Req;
  mpu_issue_no_t  O_TPU_IssueNo;
  instr_t         O_TPU_Instr;
  logic           I_TPU_Nack;
  logic           I_TPU_Term;
  mpu_issue_no_t  I_TPU_IssueNo;
  logic           O_Busy;
  logic           O_Done;
  mpu_issue_no_t  O_Done_IssueNo;
  logic           O_Timeout;

  typedef struct {
    instr_t        instr;
    mpu_issue_no_t issue;
  } beat_t;

  typedef struct {
    mpu_issue_no_t issue;
    logic          timeout;
  } done_t;

  beat_t beat_q[$];
  done_t done_q[$];
  int    checks = 0;
  int    errors = 0;

  tpu_dispatch #(
    .IADDR_W     (10),
    .LEN_W       (10),
    .WDOG_CYCLES (16)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .I_Start        (I_Start),
    .I_IssueNo      (I_IssueNo),
    .I_Base         (I_Base),
    .I_Length       (I_Length),
    .O_Start_Ack    (O_Start_Ack),
    .O_IMem_Re      (O_IMem_Re),
    .O_IMem_Addr    (O_IMem_Addr),
    .I_IMem_Instr   (I_IMem_Instr),
    .O_TPU_Req      (O_TPU_Req),
    .O_TPU_IssueNo  (O_TPU_IssueNo),
    .O_TPU_Instr    (O_TPU_Instr),
    .I_TPU_Nack     (I_TPU_Nack),
    .I_TPU_Term     (I_TPU_Term),
    .I_TPU_IssueNo  (I_TPU_IssueNo),
    .O_Busy         (O_Busy),
    .O_Done         (O_Done),
    .O_Done_IssueNo (O_Done_IssueNo),
    .O_Timeout      (O_Timeout)
  );

  always #5 clock = ~clock;

  function automatic instr_t mem_word(input logic [9:0] a);
    return 32'hC0DE_0000 | {22'b0, a};
  endfunction

  // Instruction storage: data appears the cycle after the read enable.
  always @(posedge clock) begin
    I_IMem_Instr <= O_IMem_Re ? mem_word(O_IMem_Addr) : 32'hDEAD_BEEF;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic resetCheck(input string tag);
    checkOutput({tag, "_re"},      32'(O_IMem_Re), 0);
    checkOutput({tag, "_addr"},    32'(O_IMem_Addr), 0);
    checkOutput({tag, "_req"},     32'(O_TPU_Req), 0);
    checkOutput({tag, "_instr"},   O_TPU_Instr, 0);
    checkOutput({tag, "_tissue"},  32'(O_TPU_IssueNo), 0);
    checkOutput({tag, "_busy"},    32'(O_Busy), 0);
    checkOutput({tag, "_done"},    32'(O_Done), 0);
    checkOutput({tag, "_dissue"},  32'(O_Done_IssueNo), 0);
    checkOutput({tag, "_timeout"}, 32'(O_Timeout), 0);
  endtask

  // Drives a start for one cycle, checks the ack, and queues the beats expected to be accepted.
  task automatic applyStimulus(input mpu_issue_no_t issue, input logic [9:0] base,
                               input logic [9:0] len, input logic expect_ack,
                               input int n_push);
    beat_t b;
    I_Start   = 1'b1;
    I_IssueNo = issue;
    I_Base    = base;
    I_Length  = len;
    #1;
    checkOutput("start_ack", 32'(O_Start_Ack), 32'(expect_ack));
    for (int i = 0; i < n_push; i++) begin
      b.instr = mem_word(base + 10'(i));
      b.issue = issue;
      beat_q.push_back(b);
    end
    @(posedge clock);
    #1;
    I_Start = 1'b0;
  endtask

  task automatic expectDone(input mpu_issue_no_t issue, input logic timeout);
    done_t d;
    d.issue   = issue;
    d.timeout = timeout;
    done_q.push_back(d);
  endtask

  always @(negedge clock) begin
    beat_t b;
    done_t d;
    if (reset && O_TPU_Req && !I_TPU_Nack) begin
      if (beat_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_beat: got 0x%0h, expected no beat", O_TPU_Instr);
      end else begin
        b = beat_q.pop_front();
        checkOutput("beat_instr", O_TPU_Instr, b.instr);
        checkOutput("beat_issue", 32'(O_TPU_IssueNo), 32'(b.issue));
      end
    end
    if (O_Done) begin
      if (done_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got issue %0d, expected no done", O_Done_IssueNo);
      end else begin
        d = done_q.pop_front();
        checkOutput("done_issue", 32'(O_Done_IssueNo), 32'(d.issue));
        checkOutput("done_timeout", 32'(O_Timeout), 32'(d.timeout));
      end
    end
  end

  initial begin
    logic [9:0] wrap_addr [4];
    wrap_addr = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};

    reset         = 1'b0;
    I_Start       = 1'b0;
    I_IssueNo     = '0;
    I_Base        = '0;
    I_Length      = '0;
    I_TPU_Nack    = 1'b0;
    I_TPU_Term    = 1'b0;
    I_TPU_IssueNo = '0;
    repeat (3) tick();
    resetCheck("rst");
    reset = 1'b1;
    tick();

    $display("[TB] plain 4-beat thread, issue 5");
    applyStimulus(4'd5, 10'h010, 10'd4, 1'b1, 4);
    checkOutput("t1_re_c1", 32'(O_IMem_Re), 1);
    checkOutput("t1_addr_c1", 32'(O_IMem_Addr), 32'h10);
    for (int c = 2; c <= 11; c++) begin
      tick();
      I_TPU_Term    = (c == 10);
      I_TPU_IssueNo = 4'd5;
      if (c == 10) expectDone(4'd5, 1'b0);
      if (c <= 4) begin
        checkOutput("t1_re", 32'(O_IMem_Re), 1);
        checkOutput("t1_addr", 32'(O_IMem_Addr), 32'h10 + 32'(c - 1));
      end
      if (c == 5) checkOutput("t1_re_off", 32'(O_IMem_Re), 0);
      if (c == 2) checkOutput("t1_req_c2", 32'(O_TPU_Req), 0);
      if (c == 3) checkOutput("t1_req_c3", 32'(O_TPU_Req), 1);
      if (c == 6) checkOutput("t1_req_c6", 32'(O_TPU_Req), 1);
      if (c == 7) begin
        checkOutput("t1_req_c7", 32'(O_TPU_Req), 0);
        checkOutput("t1_busy_c7", 32'(O_Busy), 1);
      end
      if (c == 11) begin
        checkOutput("t1_done", 32'(O_Done), 1);
        checkOutput("t1_busy_c11", 32'(O_Busy), 0);
      end
    end

    $display("[TB] zero-length start is ignored");
    applyStimulus(4'd9, 10'h055, 10'd0, 1'b0, 0);
    checkOutput("zero_len_busy", 32'(O_Busy), 0);

    $display("[TB] 6-beat thread with Nack on beat 2");
    applyStimulus(4'd3, 10'h040, 10'd6, 1'b1, 6);
    for (int c = 2; c <= 17; c++) begin
      tick();
      I_TPU_Nack    = (c == 2) || (c >= 5 && c <= 7);
      I_TPU_Term    = (c == 16);
      I_TPU_IssueNo = 4'd3;
      if (c == 16) expectDone(4'd3, 1'b0);
      if (c == 4) begin
        I_Start   = 1'b1;
        I_IssueNo = 4'd9;
        I_Base    = 10'h200;
        I_Length  = 10'd2;
        #1;
        checkOutput("busy_start_ack", 32'(O_Start_Ack), 0);
      end
      if (c == 5) I_Start = 1'b0;
      if (c == 3) checkOutput("t2_req_c3", 32'(O_TPU_Req), 1);
      if (c == 5) checkOutput("t2_nacked_instr", O_TPU_Instr, mem_word(10'h042));
      if (c >= 6 && c <= 10) checkOutput("t2_req_gap", 32'(O_TPU_Req), 0);
      if (c == 6) checkOutput("t2_re_backoff", 32'(O_IMem_Re), 0);
      if (c == 8) checkOutput("t2_busy_backoff", 32'(O_Busy), 1);
      if (c == 9) begin
        checkOutput("t2_refetch_re", 32'(O_IMem_Re), 1);
        checkOutput("t2_refetch_addr", 32'(O_IMem_Addr), 32'h42);
      end
      if (c == 11) begin
        checkOutput("t2_replay_req", 32'(O_TPU_Req), 1);
        checkOutput("t2_replay_instr", O_TPU_Instr, mem_word(10'h042));
      end
      if (c == 14) checkOutput("t2_req_c14", 32'(O_TPU_Req), 1);
      if (c == 15) begin
        checkOutput("t2_req_c15", 32'(O_TPU_Req), 0);
        checkOutput("t2_busy_wait", 32'(O_Busy), 1);
      end
      if (c == 17) checkOutput("t2_done", 32'(O_Done), 1);
    end

    $display("[TB] address wrap and mismatched Term");
    applyStimulus(4'd5, 10'h3FE, 10'd4, 1'b1, 4);
    checkOutput("t3_addr_c1", 32'(O_IMem_Addr), 32'(wrap_addr[0]));
    for (int c = 2; c <= 11; c++) begin
      tick();
      I_TPU_Term    = (c == 8) || (c == 10);
      I_TPU_IssueNo = (c == 8) ? 4'd7 : 4'd5;
      if (c == 10) expectDone(4'd5, 1'b0);
      if (c <= 4) checkOutput("t3_addr", 32'(O_IMem_Addr), 32'(wrap_addr[c - 1]));
      if (c == 9) begin
        checkOutput("t3_no_done_mismatch", 32'(O_Done), 0);
        checkOutput("t3_busy_c9", 32'(O_Busy), 1);
      end
      if (c == 11) checkOutput("t3_done", 32'(O_Done), 1);
    end

    $display("[TB] start in Done cycle, early Term latched");
    applyStimulus(4'd6, 10'h080, 10'd3, 1'b1, 3);
    for (int c = 2; c <= 8; c++) begin
      tick();
      I_TPU_Term    = (c == 2);
      I_TPU_IssueNo = 4'd6;
      if (c == 2) expectDone(4'd6, 1'b0);
      if (c == 6) begin
        checkOutput("t4_no_done_c6", 32'(O_Done), 0);
        checkOutput("t4_busy_c6", 32'(O_Busy), 1);
      end
      if (c == 7) checkOutput("t4_done_c7", 32'(O_Done), 1);
    end

    $display("[TB] reset during beat 3 of 8");
    applyStimulus(4'd2, 10'h100, 10'd8, 1'b1, 3);
    for (int c = 2; c <= 12; c++) begin
      tick();
      I_TPU_Term    = (c == 9);
      I_TPU_IssueNo = 4'd2;
      if (c == 6) begin
        checkOutput("t5_beat3_req", 32'(O_TPU_Req), 1);
        reset = 1'b0;
      end
      if (c == 7) resetCheck("t5_mid");
      if (c == 8) reset = 1'b1;
      if (c >= 9) begin
        checkOutput("t5_no_done", 32'(O_Done), 0);
        checkOutput("t5_idle", 32'(O_Busy), 0);
      end
    end
    applyStimulus(4'd4, 10'h020, 10'd2, 1'b1, 2);
    for (int c = 2; c <= 7; c++) begin
      tick();
      I_TPU_Term    = (c == 6);
      I_TPU_IssueNo = 4'd4;
      if (c == 6) expectDone(4'd4, 1'b0);
      if (c == 7) checkOutput("t5_fresh_done", 32'(O_Done), 1);
    end

    $display("[TB] Term never arrives");
    applyStimulus(4'd1, 10'h000, 10'd1, 1'b1, 1);
`ifdef TPU_DISPATCH_WDOG_EN
    expectDone(4'd1, 1'b1);
`endif
    for (int c = 2; c <= 21; c++) begin
      tick();
`ifdef TPU_DISPATCH_WDOG_EN
      if (c == 19) begin
        checkOutput("wd_no_done_c19", 32'(O_Done), 0);
        checkOutput("wd_busy_c19", 32'(O_Busy), 1);
      end
      if (c == 20) begin
        checkOutput("wd_done", 32'(O_Done), 1);
        checkOutput("wd_timeout", 32'(O_Timeout), 1);
        checkOutput("wd_busy_c20", 32'(O_Busy), 0);
      end
`else
      if (c == 20 || c == 21) begin
        checkOutput("nowd_busy", 32'(O_Busy), 1);
        checkOutput("nowd_timeout", 32'(O_Timeout), 0);
      end
`endif
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    checkOutput("beat_queue_empty", 32'(beat_q.size()), 0);
    checkOutput("done_queue_empty", 32'(done_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
